vram_scan_reader: RTL and testbench
===================================

// Module: vram_scan_reader
// PURPOSE
//  Read-side initiator for the 16Kx8 dual-port video RAM (port B, 2-cycle pipelined read).
//  Per frame, walks character addresses from a base address and fetches one byte per character cell.
//  Delivers bytes in order to the character-generator/pixel path over a valid/ready stream,
//  tagged with start-of-line and end-of-frame. The CPU side owns port A; this block never writes.
// PARAMETERS
//  ADDR_W      14   VRAM address width; address arithmetic wraps modulo 2**ADDR_W
//  DATA_W      8    VRAM / character data width
//  FIFO_DEPTH  4    output buffer entries (power of 2, >=4 for full rate)
// PORTS
//  clk          in   1       single clock for the block and VRAM port B
//  reset_n      in   1       asynchronous, active-low reset
//  frame_start  in   1       1-cycle pulse: begin a frame (ignored unless idle)
//  mode_80      in   1       sampled on frame_start: 1 = 80x24 (1920 cells), 0 = 64x16 (1024 cells)
//  base_addr    in   ADDR_W  sampled on frame_start: address of cell (0,0)
//  ram_ad       out  ADDR_W  VRAM port-B address
//  ram_ce       out  1       VRAM port-B clock enable = read issue strobe
//  ram_oce      out  1       VRAM port-B output-register enable; constant 1 after reset
//  ram_wre      out  1       VRAM port-B write enable; constant 0
//  ram_dout     in   DATA_W  VRAM port-B read data
//  char_data    out  DATA_W  fetched character byte
//  char_sol     out  1       char_data is column 0 of a row
//  char_eof     out  1       char_data is the last cell of the frame
//  char_valid   out  1       stream valid
//  char_ready   in   1       stream ready; transfer when valid & ready
//  busy         out  1       frame in progress (FETCH or DRAIN)
//  frame_done   out  1       1-cycle pulse once the last cell has been transferred
// BEHAVIOUR
//  Reset: ram_ad=0, ram_ce=0, ram_oce=1, ram_wre=0, char_valid=0, char_sol=0, char_eof=0, char_data=0,
//   busy=0, frame_done=0; FSM=IDLE; FIFO and in-flight pipe emptied. Reset mid-frame abandons the frame.
//  FSM IDLE -> FETCH on frame_start: latch mode/base; addr=base, col=0, row=0.
//   FETCH: issue a read (ram_ce=1, ram_ad=addr) in any cycle where fifo_count + inflight < FIFO_DEPTH
//   (both registered values; a pop this cycle frees space only next cycle). Per issue: addr=addr+1
//   (wraps 2**ADDR_W-1 -> 0); col++; col==COLS-1 -> col=0, row++. Issue of last cell -> DRAIN.
//   DRAIN: no issues; -> IDLE when inflight==0 and FIFO empty, pulsing frame_done that same transition.
//   frame_start in FETCH/DRAIN ignored. busy=1 in FETCH and DRAIN.
//  Read latency: issue at cycle N -> ram_dout valid at N+2; a 2-stage tag pipe (valid, sol, eof)
//   tracks in-flight reads; at N+2 {ram_dout,sol,eof} pushes into the FIFO. Credit rule guarantees no overflow.
//  Stream: char_* are driven from the FIFO head; valid holds and data/tags stay stable until accepted.
//   FIFO empty -> char_valid=0. Push to empty FIFO is visible at the next cycle (first char at N+3).
//   Simultaneous push and pop: count unchanged, order preserved.
//  Throughput: with char_ready=1, one issue per cycle and one char per cycle sustained.
//  COLS/ROWS: 64/16 when mode_80=0, 80/24 when mode_80=1; exactly COLS*ROWS chars per frame.
// STRUCTURE
//  Package vram_scan_pkg: COLS_64=64, ROWS_64=16, COLS_80=80, ROWS_80=24, RD_LATENCY=2,
//   typedef of scan state enum {IDLE,FETCH,DRAIN}.
//  Sub-module sync_fifo (DATA_W+2 wide, FIFO_DEPTH deep, count output): the FIFO; FSM, counters
//   and tag pipe stay in this module.
// TESTING
//  Bench models port B as 2-cycle pipelined RAM, mem[a] = a[7:0] ^ 8'h5A.
//  1. 64x16, base=0x0000, ready=1 -> 1024 chars, addr 0x000..0x3FF in order, sol every 64, eof on 1024th,
//     frame_done one cycle after that transfer, one issue per cycle.
//  2. 80x24, base=0x1000, ready toggled pseudo-randomly -> 1920 chars in order, sol every 80, no
//     loss/duplication, ram_ce never raised while fifo_count+inflight==4.
//  3. Backpressure: ready=0 for 20 cycles mid-row -> exactly 4 reads issued then ram_ce=0; char_data stable;
//     resume with no loss.
//  4. Wrap: base=0x3FF0, 64x16 -> addresses 0x3FF0..0x3FFF then 0x0000..0x03EF.
//  5. frame_start pulsed while busy -> ignored, frame completes unchanged; reset_n low mid-FETCH ->
//     all outputs at reset values immediately, next frame_start starts clean.
//  6. Latency: single frame, ready=1 -> first ram_ce at cycle 1 after frame_start, first char_valid 3 cycles later.

Source files
------------

// File: rtl/vram_scan_reader_pkg.sv
// Shared constants and types for the VRAM scan reader: screen geometry, read latency,
// scan FSM states and the per-read tag carried alongside an in-flight VRAM access.
package vram_scan_pkg;
  localparam int COLS_64    = 64;
  localparam int ROWS_64    = 16;
  localparam int COLS_80    = 80;
  localparam int ROWS_80    = 24;
  localparam int RD_LATENCY = 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} scan_state_e;

  typedef struct packed {
    logic vld;
    logic sol;
    logic eof;
  } rd_tag_t;
endpackage

// File: rtl/vram_scan_reader_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is visible combinationally.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/vram_scan_reader.sv
// Walks one frame of character cells out of VRAM port B and streams the bytes, tagged with
// start-of-line / end-of-frame, through a credit-limited FIFO to the pixel path.
module vram_scan_reader
  import vram_scan_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              mode_80,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] ram_ad,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] char_data,
  output logic              char_sol,
  output logic              char_eof,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(RD_LATENCY + 1);
  localparam int SW = CW + 1;
  localparam int FW = DATA_W + 2;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        col_q, col_d, cols;
  logic [4:0]        row_q, row_d, rows;
  logic              mode_q, mode_d;
  rd_tag_t           pipe_q [1:RD_LATENCY];
  logic [IW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty, has_credit, last_col, last_row, pop;
  logic [FW-1:0]     fifo_head;

  assign cols     = mode_q ? 7'(COLS_80) : 7'(COLS_64);
  assign rows     = mode_q ? 5'(ROWS_80) : 5'(ROWS_64);
  assign last_col = (col_q == cols - 7'd1);
  assign last_row = (row_q == rows - 5'd1);

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= RD_LATENCY; i++) inflight = inflight + IW'(pipe_q[i].vld);
  end

  // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
  assign has_credit = (SW'(fifo_cnt) + SW'(inflight)) < SW'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    mode_d     = mode_q;
    ram_ce     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: if (frame_start) begin
        state_d = FETCH;
        mode_d  = mode_80;
        addr_d  = base_addr;
        col_d   = '0;
        row_d   = '0;
      end
      FETCH: if (has_credit) begin
        ram_ce = 1'b1;
        addr_d = addr_q + 1'b1;
        if (last_col) begin
          col_d = '0;
          row_d = row_q + 5'd1;
          if (last_row) state_d = DRAIN;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      DRAIN: if ((inflight == '0) && fifo_empty) begin
        state_d    = IDLE;
        frame_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= 1'b0;
      for (int i = 1; i <= RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      pipe_q[1] <= '{vld: ram_ce, sol: (col_q == '0), eof: (last_col && last_row)};
      for (int i = 2; i <= RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pop = char_valid && char_ready;

  sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (pipe_q[RD_LATENCY].vld),
    .wdata_i ({ram_dout, pipe_q[RD_LATENCY].sol, pipe_q[RD_LATENCY].eof}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Stream fields are forced to zero when nothing is buffered.
  assign char_valid = !fifo_empty;
  assign {char_data, char_sol, char_eof} = fifo_empty ? '0 : fifo_head;

  assign ram_ad  = addr_q;
  assign ram_oce = 1'b1;
  assign ram_wre = 1'b0;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_vram_scan_reader.sv
// Directed bench for vram_scan_reader with a 2-cycle pipelined port-B model (mem[a] = a[7:0]^5A).
module tb_vram_scan_reader;
  logic        clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0, mode_80 = 1'b0, char_ready = 1'b0;
  logic [13:0] base_addr = '0, ram_ad;
  logic        ram_ce, ram_oce, ram_wre, char_sol, char_eof, char_valid, busy, frame_done;
  logic [7:0]  ram_dout = '0, ram_q1 = '0, char_data;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  vram_scan_reader dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .mode_80(mode_80),
    .base_addr(base_addr), .ram_ad(ram_ad), .ram_ce(ram_ce), .ram_oce(ram_oce),
    .ram_wre(ram_wre), .ram_dout(ram_dout), .char_data(char_data), .char_sol(char_sol),
    .char_eof(char_eof), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always @(posedge clk) begin
    if (ram_ce)  ram_q1   <= ram_ad[7:0] ^ 8'h5A;
    if (ram_oce) ram_dout <= ram_q1;
  end

  // rmode: 0 = ready always, 1 = random ready, 2 = 20-cycle stall after 100 transfers.
  task automatic run_frame(input string tag, input logic m80, input logic [13:0] base,
                           input int rmode, input int poke_cyc);
    int cols, cells, issued, xfers, cyc, last_xfer, stall_cnt, first_ce, first_vld;
    bit done;
    logic [7:0]  hold_data;
    logic [13:0] ea;
    cols = m80 ? 80 : 64;
    cells = m80 ? 1920 : 1024;
    issued = 0; xfers = 0; cyc = 0; last_xfer = -10; stall_cnt = 0;
    first_ce = -1; first_vld = -1; done = 0; hold_data = '0;
    @(negedge clk);
    mode_80 = m80; base_addr = base; frame_start = 1'b1; char_ready = 1'b1;
    while (!done && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      frame_start = (cyc == poke_cyc);
      mode_80 = ~m80;
      base_addr = ~base;
      case (rmode)
        1: char_ready = ($urandom_range(0, 3) != 0);
        2: if (xfers >= 100 && stall_cnt < 20) begin char_ready = 1'b0; stall_cnt++; end
           else char_ready = 1'b1;
        default: char_ready = 1'b1;
      endcase
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy cyc=%0d got %b exp 1", tag, cyc, busy); end
      if (rmode == 2 && !char_ready) begin
        if (stall_cnt == 1) hold_data = char_data;
        else begin
          checks++;
          if (char_valid !== 1'b1 || char_data !== hold_data) begin
            errors++;
            $display("FAIL %s stall_hold cyc=%0d got v=%b d=%h exp v=1 d=%h", tag, cyc, char_valid, char_data, hold_data);
          end
        end
        if (stall_cnt == 20) begin
          checks++;
          if (ram_ce !== 1'b0 || issued - xfers != 4) begin
            errors++;
            $display("FAIL %s stall_credit got ce=%b outstanding=%0d exp ce=0 outstanding=4", tag, ram_ce, issued - xfers);
          end
        end
      end
      if (char_valid && first_vld < 0) first_vld = cyc;
      if (ram_ce) begin
        ea = base + 14'(issued);
        checks++;
        if (issued - xfers >= 4 || issued >= cells) begin
          errors++;
          $display("FAIL %s credit cyc=%0d got outstanding=%0d issued=%0d exp <4 and <%0d", tag, cyc, issued - xfers, issued, cells);
        end
        checks++;
        if (ram_ad !== ea) begin
          errors++;
          $display("FAIL %s addr idx=%0d got %h exp %h", tag, issued, ram_ad, ea);
        end
        if (rmode == 0) begin
          checks++;
          if (cyc != issued + 1) begin
            errors++;
            $display("FAIL %s issue_rate idx=%0d got cyc %0d exp cyc %0d", tag, issued, cyc, issued + 1);
          end
        end
        if (first_ce < 0) first_ce = cyc;
        issued++;
      end
      if (char_valid && char_ready) begin
        ea = base + 14'(xfers);
        checks++;
        if ({char_data, char_sol, char_eof} !== {ea[7:0] ^ 8'h5A, (xfers % cols) == 0, xfers == cells - 1}) begin
          errors++;
          $display("FAIL %s xfer idx=%0d got d=%h sol=%b eof=%b exp d=%h sol=%b eof=%b", tag, xfers,
                   char_data, char_sol, char_eof, ea[7:0] ^ 8'h5A, (xfers % cols) == 0, xfers == cells - 1);
        end
        xfers++;
        last_xfer = cyc;
      end
      if (frame_done) begin
        checks++;
        if (xfers != cells || cyc != last_xfer + 1) begin
          errors++;
          $display("FAIL %s done_timing got cyc=%0d xfers=%0d exp cyc=%0d xfers=%0d", tag, cyc, xfers, last_xfer + 1, cells);
        end
        done = 1;
      end
    end
    frame_start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout got no frame_done exp frame_done", tag); end
    checks++;
    if (issued != cells || xfers != cells) begin
      errors++;
      $display("FAIL %s count got issued=%0d xfers=%0d exp %0d", tag, issued, xfers, cells);
    end
    if (rmode == 0) begin
      checks++;
      if (first_ce != 1 || first_vld != 4) begin
        errors++;
        $display("FAIL %s latency got ce@%0d valid@%0d exp ce@1 valid@4", tag, first_ce, first_vld);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, frame_done, char_valid, ram_ce} !== 4'b0000) begin
      errors++;
      $display("FAIL %s idle_after got busy=%b done=%b valid=%b ce=%b exp 0000", tag, busy, frame_done, char_valid, ram_ce);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ram_ad, ram_ce, ram_oce, ram_wre} !== {14'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_ram got ad=%h ce=%b oce=%b wre=%b exp 0000 0 1 0", ram_ad, ram_ce, ram_oce, ram_wre);
    end
    checks++;
    if ({char_valid, char_sol, char_eof, char_data, busy, frame_done} !== 13'h0) begin
      errors++;
      $display("FAIL reset_stream got v=%b sol=%b eof=%b d=%h busy=%b done=%b exp all 0",
               char_valid, char_sol, char_eof, char_data, busy, frame_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_rate;    run_frame("full_rate_64x16", 1'b0, 14'h0000, 0, -1); endtask
  task automatic test_random_ready; run_frame("random_80x24",    1'b1, 14'h1000, 1, -1); endtask
  task automatic test_backpressure; run_frame("backpressure",    1'b0, 14'h0800, 2, -1); endtask
  task automatic test_wrap;         run_frame("wrap_3ff0",       1'b0, 14'h3FF0, 0, -1); endtask
  task automatic test_ignore_start; run_frame("ignore_start",    1'b1, 14'h2345, 0, 300); endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    mode_80 = 1'b0; base_addr = 14'h0200; frame_start = 1'b1; char_ready = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || char_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got busy=%b valid=%b exp 1 1", busy, char_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_ad, ram_ce, ram_oce, ram_wre, char_valid, char_sol, char_eof, char_data, busy, frame_done}
        !== {14'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs got ad=%h ce=%b oce=%b wre=%b v=%b sol=%b eof=%b d=%h busy=%b done=%b exp reset values",
               ram_ad, ram_ce, ram_oce, ram_wre, char_valid, char_sol, char_eof, char_data, busy, frame_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame("after_reset", 1'b0, 14'h0040, 0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_rate();
    test_random_ready();
    test_backpressure();
    test_wrap();
    test_ignore_start();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
